// File: rtl/cart_pkg.sv
// Shared types and constants for the cartridge ROM fetch path.
package cart_pkg;

    localparam int         CART_ADDR_W = 25;
    localparam logic [7:0] OPEN_BUS    = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/cart_fetch_buf.sv
// Single-entry last-byte buffer keyed on the physical SDRAM address.
module cart_fetch_buf
    import cart_pkg::*;
#(
    parameter int ADDR_W = 27
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              fill_i,
    input  logic [ADDR_W-1:0] fill_tag_i,
    input  logic [7:0]        fill_data_i,
    input  logic [ADDR_W-1:0] lookup_i,
    output logic              hit_o,
    output logic [7:0]        data_o
);

    logic              valid_q;
    logic [ADDR_W-1:0] tag_q;
    logic [7:0]        data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= OPEN_BUS;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (fill_i) begin
            valid_q <= 1'b1;
            tag_q   <= fill_tag_i;
            data_q  <= fill_data_i;
        end
    end

    // A flush in the same cycle as a lookup already counts as empty.
    assign hit_o  = valid_q & ~flush_i & (tag_q == lookup_i);
    assign data_o = data_q;

endmodule

// File: rtl/cart_rom_fetch.sv
// Cartridge ROM fetch: serves CPU reads from SDRAM through a one-byte buffer,
// stalling the Z80 with cpu_wait while a fetch is outstanding.
//
// state | meaning
// IDLE  | waiting for a new read access
// REQ   | SDRAM request outstanding, CPU stalled
// DONE  | data presented, waiting for the CPU to release the access
module cart_rom_fetch
    import cart_pkg::*;
#(
    parameter int ADDR_W  = 27,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cs,
    input  logic                   cpu_mreq,
    input  logic                   cpu_rd,
    input  logic [CART_ADDR_W-1:0] mem_addr,
    input  logic                   mem_unmaped,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic                   inval,
    output logic [7:0]             dout,
    output logic                   cpu_wait,
    output logic [ADDR_W-1:0]      ram_addr,
    output logic                   ram_req,
    input  logic                   ram_ack,
    input  logic [7:0]             ram_din,
    output logic                   timeout_err
);

    localparam logic [15:0] TMR_LOAD = 16'(TIMEOUT - 1);

    fetch_state_t      state_q, state_d;
    logic              acc, acc_q, new_acc, hit, fill, tmr_zero;
    logic [ADDR_W-1:0] phys, ram_addr_q, ram_addr_d;
    logic [7:0]        buf_data, dout_q, dout_d;
    logic              ram_req_q, ram_req_d, terr_q, terr_d, skip_fill_q, skip_fill_d;
    logic [15:0]       tmr_q, tmr_d;

    assign acc      = cs & cpu_mreq & cpu_rd;
    assign new_acc  = acc & ~acc_q;
    assign phys     = base_addr + ADDR_W'(mem_addr);
    assign tmr_zero = (tmr_q == 16'd0);
    // A fetch raced by a flush still returns its byte but must not repopulate the buffer.
    assign fill     = (state_q == REQ) & ram_ack & ~skip_fill_q & ~inval;

    cart_fetch_buf #(.ADDR_W(ADDR_W)) u_buf (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (inval),
        .fill_i     (fill),
        .fill_tag_i (ram_addr_q),
        .fill_data_i(ram_din),
        .lookup_i   (phys),
        .hit_o      (hit),
        .data_o     (buf_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= 1'b0;
            dout_q      <= OPEN_BUS;
            ram_req_q   <= 1'b0;
            ram_addr_q  <= '0;
            terr_q      <= 1'b0;
            skip_fill_q <= 1'b0;
            tmr_q       <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc;
            dout_q      <= dout_d;
            ram_req_q   <= ram_req_d;
            ram_addr_q  <= ram_addr_d;
            terr_q      <= terr_d;
            skip_fill_q <= skip_fill_d;
            tmr_q       <= tmr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (new_acc) state_d = (mem_unmaped | hit) ? DONE : REQ;
            REQ:     if (ram_ack | tmr_zero) state_d = acc ? DONE : IDLE;
            DONE:    if (!acc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dout_d      = dout_q;
        ram_req_d   = ram_req_q;
        ram_addr_d  = ram_addr_q;
        tmr_d       = tmr_q;
        skip_fill_d = skip_fill_q;
        terr_d      = terr_q & ~inval;
        case (state_q)
            IDLE: if (new_acc) begin
                if (mem_unmaped) begin
                    dout_d = OPEN_BUS;
                end else if (hit) begin
                    dout_d = buf_data;
                end else begin
                    ram_addr_d  = phys;
                    ram_req_d   = 1'b1;
                    tmr_d       = TMR_LOAD;
                    skip_fill_d = inval;
                end
            end
            REQ: begin
                if (inval) skip_fill_d = 1'b1;
                if (ram_ack) begin
                    ram_req_d = 1'b0;
                    dout_d    = ram_din;
                end else if (tmr_zero) begin
                    ram_req_d = 1'b0;
                    dout_d    = OPEN_BUS;
                    terr_d    = 1'b1;
                end else begin
                    tmr_d = tmr_q - 16'd1;
                end
            end
            default: ;
        endcase
        cpu_wait = ((state_q == IDLE) & new_acc & ~mem_unmaped & ~hit) | (state_q == REQ);
    end

    assign dout        = dout_q;
    assign ram_addr    = ram_addr_q;
    assign ram_req     = ram_req_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_cart_rom_fetch.sv
// Scoreboard bench for cart_rom_fetch: a driver issues CPU reads against a
// behavioural buffer model; a monitor checks each completed read and SDRAM request.
module tb_cart_rom_fetch;
    import cart_pkg::*;

    localparam int AW  = 27;
    localparam int TMO = 8;

    logic          clk, reset, cs, cpu_mreq, cpu_rd, mem_unmaped, inval;
    logic [24:0]   mem_addr;
    logic [AW-1:0] base_addr, ram_addr;
    logic [7:0]    dout, ram_din;
    logic          cpu_wait, ram_req, ram_ack, timeout_err;

    cart_rom_fetch #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .cs(cs), .cpu_mreq(cpu_mreq), .cpu_rd(cpu_rd),
        .mem_addr(mem_addr), .mem_unmaped(mem_unmaped), .base_addr(base_addr),
        .inval(inval), .dout(dout), .cpu_wait(cpu_wait), .ram_addr(ram_addr),
        .ram_req(ram_req), .ram_ack(ram_ack), .ram_din(ram_din),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [7:0] d; int w; logic terr; } rsp_t;
    typedef struct { logic [AW-1:0] a; int n; } req_t;

    rsp_t rsp_q[$];
    req_t req_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    // Reference model of the buffer and sticky timeout flag
    bit            m_valid = 1'b0;
    logic [AW-1:0] m_tag   = '0;
    logic [7:0]    m_data  = 8'hFF;
    logic          m_terr  = 1'b0;

    logic [24:0]   addr_pool [4] = '{25'h0_0010, 25'h0_0011, 25'h1FF_FFFF, 25'h0_ABCD};
    logic [AW-1:0] base_pool [4] = '{27'h000_0000, 27'h010_0000, 27'h7FF_FFFF, 27'h700_0000};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] memfn(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ {5'd0, a[26:24]} ^ 8'h5A;
    endfunction

    // k = ack cycle within REQ (0 means never ack); inval_at/abort_at = REQ cycle, 0 = none
    task automatic do_read(input logic [AW-1:0] base, input logic [24:0] a, input bit unm,
                           input int k, input int inval_at, input int abort_at,
                           input bit fz, input logic [7:0] fdin);
        logic [AW-1:0] p;
        rsp_t e;
        req_t r;
        bit   miss;
        int   n;
        p      = base + AW'(a);
        miss   = !unm && !(m_valid && m_tag == p);
        n      = (k == 0) ? TMO : k;
        e.terr = m_terr;
        e.w    = 0;
        if (unm) begin
            e.d = 8'hFF;
        end else if (!miss) begin
            e.d = m_data;
        end else begin
            r.a = p;
            r.n = n;
            req_q.push_back(r);
            if (inval_at != 0) begin
                m_valid = 1'b0;
                m_terr  = 1'b0;
            end
            if (k == 0) begin
                e.d    = 8'hFF;
                m_terr = 1'b1;
            end else begin
                e.d = fz ? fdin : memfn(p);
                if (inval_at == 0) begin
                    m_valid = 1'b1;
                    m_tag   = p;
                    m_data  = e.d;
                end
            end
            e.w    = n + 1;
            e.terr = m_terr;
        end
        rsp_q.push_back(e);

        @(negedge clk);
        base_addr = base; mem_addr = a; mem_unmaped = unm;
        cs = 1'b1; cpu_mreq = 1'b1; cpu_rd = 1'b1;
        if (miss) begin
            for (int c = 1; c <= n; c++) begin
                @(negedge clk);
                inval   = (c == inval_at);
                if (c == abort_at) cs = 1'b0;
                ram_ack = (k != 0 && c == k);
                ram_din = ram_ack ? (fz ? fdin : memfn(ram_addr)) : 8'($urandom);
            end
        end
        @(negedge clk);
        ram_ack = 1'b0; inval = 1'b0;
        @(negedge clk);
        cs = 1'b0; cpu_mreq = 1'b0; cpu_rd = 1'b0; mem_unmaped = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_inval();
        @(negedge clk); inval = 1'b1;
        @(negedge clk); inval = 1'b0;
        m_valid = 1'b0;
        m_terr  = 1'b0;
    endtask

    task automatic stray_ack();
        @(negedge clk); ram_ack = 1'b1; ram_din = 8'($urandom);
        @(negedge clk); ram_ack = 1'b0;
    endtask

    // Monitor: a read completes on the first non-stalled cycle after its access edge
    initial begin
        bit   prev_acc = 1'b0, prev_req = 1'b0, pending = 1'b0, acc_now;
        int   wcnt = 0, rlen = 0, exp_len = 0;
        rsp_t e;
        req_t r;
        forever begin
            @(negedge clk); #1;
            if (!mon_en) begin
                prev_acc = 1'b0; prev_req = 1'b0; pending = 1'b0;
                continue;
            end
            acc_now = cs & cpu_mreq & cpu_rd;
            if (pending) begin
                if (cpu_wait) begin
                    wcnt++;
                    if (wcnt > 64) begin
                        check("wait_bound", 32'(wcnt), 32'd64);
                        pending = 1'b0;
                    end
                end else begin
                    pending = 1'b0;
                    if (rsp_q.size() == 0) begin
                        check("rsp_underflow", 32'(rsp_q.size()), 32'd1);
                    end else begin
                        e = rsp_q.pop_front();
                        check("dout", 32'(dout), 32'(e.d));
                        check("wait_cycles", 32'(wcnt), 32'(e.w));
                        check("timeout_err", 32'(timeout_err), 32'(e.terr));
                    end
                end
            end else if (acc_now && !prev_acc) begin
                pending = 1'b1;
                wcnt    = cpu_wait ? 1 : 0;
            end
            if (ram_req && !prev_req) begin
                if (req_q.size() == 0) begin
                    check("unexpected_req", 32'(ram_req), 32'd0);
                    exp_len = 0;
                end else begin
                    r = req_q.pop_front();
                    check("ram_addr", 32'(ram_addr), 32'(r.a));
                    exp_len = r.n;
                end
                rlen = 1;
            end else if (ram_req) begin
                rlen++;
            end else if (prev_req) begin
                check("req_cycles", 32'(rlen), 32'(exp_len));
            end
            prev_acc = acc_now;
            prev_req = ram_req;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [24:0]   a;
        logic [AW-1:0] cur_base;
        bit            unm;
        int            k, n, iv, ab;

        cs = 0; cpu_mreq = 0; cpu_rd = 0; mem_addr = '0; mem_unmaped = 0;
        base_addr = '0; inval = 0; ram_ack = 0; ram_din = 8'h00;
        reset = 1'b0;
        #1 reset = 1'b1;
        #2;
        check("rst_dout", 32'(dout), 32'hFF);
        check("rst_wait", 32'(cpu_wait), 32'd0);
        check("rst_req", 32'(ram_req), 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_terr", 32'(timeout_err), 32'd0);
        @(negedge clk); @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;

        do_read(27'h0, 25'h0_1234, 1, 0, 0, 0, 0, 8'h00);
        do_read(27'h010_0000, 25'h0_2005, 0, 5, 0, 0, 1, 8'hA5);
        do_read(27'h010_0000, 25'h0_2005, 0, 0, 0, 0, 0, 8'h00);
        pulse_inval();
        do_read(27'h010_0000, 25'h0_2005, 0, 3, 0, 0, 0, 8'h00);
        do_read(27'h010_0000, 25'h0_0777, 0, 0, 0, 0, 0, 8'h00);
        do_read(27'h010_0000, 25'h0_0777, 0, 2, 0, 0, 0, 8'h00);
        do_read(27'h010_0000, 25'h0_0400, 0, 4, 2, 3, 1, 8'h3C);
        repeat (4) @(negedge clk);
        do_read(27'h010_0000, 25'h0_0400, 0, 1, 0, 0, 0, 8'h00);
        do_read(27'h7FF_FFFF, 25'h0_0002, 0, 2, 0, 0, 0, 8'h00);
        do_read(27'h7FF_FFFF, 25'h0_0002, 0, 0, 0, 0, 0, 8'h00);

        cur_base = base_pool[1];
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) < 3) cur_base = base_pool[$urandom_range(0, 3)];
            if ($urandom_range(0, 9) == 0) pulse_inval();
            if ($urandom_range(0, 9) == 0) stray_ack();
            a   = addr_pool[$urandom_range(0, 3)];
            unm = ($urandom_range(0, 4) == 0);
            k   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
            n   = (k == 0) ? TMO : k;
            iv  = ($urandom_range(0, 6) == 0) ? int'($urandom_range(1, n)) : 0;
            ab  = ($urandom_range(0, 6) == 0) ? int'($urandom_range(1, n)) : 0;
            do_read(cur_base, a, unm, k, iv, ab, 0, 8'h00);
        end

        // Fill the buffer, then reset in the middle of a different fetch
        do_read(27'h010_0000, 25'h0_5555, 0, 1, 0, 0, 0, 8'h00);
        repeat (2) @(negedge clk);
        check("sb_rsp_drain", 32'(rsp_q.size()), 32'd0);
        check("sb_req_drain", 32'(req_q.size()), 32'd0);
        mon_en = 1'b0;
        @(negedge clk);
        base_addr = 27'h010_0000; mem_addr = 25'h0_6666;
        cs = 1'b1; cpu_mreq = 1'b1; cpu_rd = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_req_active", 32'(ram_req), 32'd1);
        #2;
        reset = 1'b1; cs = 1'b0; cpu_mreq = 1'b0; cpu_rd = 1'b0;
        #1;
        check("arst_dout", 32'(dout), 32'hFF);
        check("arst_wait", 32'(cpu_wait), 32'd0);
        check("arst_req", 32'(ram_req), 32'd0);
        check("arst_addr", 32'(ram_addr), 32'd0);
        check("arst_terr", 32'(timeout_err), 32'd0);
        @(negedge clk);
        reset   = 1'b0;
        m_valid = 1'b0;
        m_terr  = 1'b0;
        rsp_q.delete();
        req_q.delete();
        mon_en = 1'b1;
        do_read(27'h010_0000, 25'h0_5555, 0, 2, 0, 0, 0, 8'h00);
        repeat (3) @(negedge clk);
        check("final_rsp_drain", 32'(rsp_q.size()), 32'd0);
        check("final_req_drain", 32'(req_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cart_rom_fetch.md
Name: cart_rom_fetch

Overview:
- Memory-side responder behind a cartridge bank mapper.
- Takes the mapper's translated ROM address and unmapped flag for each CPU read in the cartridge slot. Fetches the byte from the shared SDRAM over a req/ack handshake and stalls the Z80 with cpu_wait until the data is available.
- Holds a single-entry last-byte buffer so repeated reads of the same ROM byte skip SDRAM.
- Unmapped reads return 0xFF without any SDRAM traffic.

Parameters:
- ADDR_W, 27, width of the SDRAM byte address.
- TIMEOUT, 255, maximum cycles to wait for ram_ack before abandoning the fetch (1..65535).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cs  in  1  cartridge slot selected.
- cpu_mreq  in  1  Z80 memory request.
- cpu_rd  in  1  Z80 read strobe.
- mem_addr  in  25  translated ROM byte offset from the mapper.
- mem_unmaped  in  1  mapper reports the address is outside the ROM or outside the window.
- base_addr  in  ADDR_W  SDRAM base of the loaded cartridge image.
- inval  in  1  one-cycle pulse that flushes the buffer on cartridge load or swap.
- dout  out  8  read data to the CPU data bus.
- cpu_wait  out  1  Z80 WAIT request, active high.
- ram_addr  out  ADDR_W  SDRAM byte address.
- ram_req  out  1  SDRAM read request, level.
- ram_ack  in  1  one-cycle acknowledge; ram_din is valid in the same cycle.
- ram_din  in  8  SDRAM read data.
- timeout_err  out  1  sticky flag, set on timeout, cleared by reset or inval.

Behaviour:
- Reset values: state=IDLE, dout=0xFF, cpu_wait=0, ram_req=0, ram_addr=0, timeout_err=0, buffer valid=0, buffer tag=0, buffer data=0xFF.
- acc = cs & cpu_mreq & cpu_rd. A new access is the rising edge of acc, detected against a registered copy of acc.
- phys = base_addr + zero-extended mem_addr, truncated to ADDR_W bits; wraps silently.
- FSM states: IDLE, REQ, DONE.
- IDLE, on a new access:
  - mem_unmaped=1: dout<=0xFF, go to DONE, no ram_req.
  - Buffer hit (valid & tag==phys): dout<=buffer data, go to DONE.
  - Otherwise: ram_addr<=phys, ram_req<=1, clear the timeout counter, go to REQ.
- REQ:
  - ram_ack: ram_req<=0, dout<=ram_din, tag<=ram_addr, data<=ram_din, valid<=1, go to DONE.
  - Counter reaches TIMEOUT: ram_req<=0, dout<=0xFF, timeout_err<=1, buffer untouched, go to DONE.
- DONE: return to IDLE when acc=0. A new access is accepted only after acc has dropped.
- cpu_wait is combinational: high when (new access & ~mem_unmaped & ~hit), or while state==REQ. It is low in DONE and IDLE. Hits and unmapped reads therefore never stall.
- Latency:
  - Hit or unmapped: dout valid 1 cycle after the access edge.
  - Miss: dout valid the cycle after ram_ack.
- ram_req stays high until ram_ack; it never pulses. At most one request is outstanding.
- inval:
  - Clears valid and timeout_err in any state.
  - If it arrives during REQ, the fetch completes and returns data to the CPU, but the buffer is not refilled.
- acc dropping during REQ (CPU abort): the fetch still completes, then the FSM goes to IDLE directly, skipping DONE.
- Writes (cpu_rd=0) are ignored entirely; the mapper handles bank writes. The buffer is keyed on physical address, so bank changes need no flush.
- ram_ack while in IDLE or DONE is ignored.

Decomposition:
- Shared package cart_pkg:
  - typedef fetch_state_t {IDLE, REQ, DONE}.
  - Constants: CART_ADDR_W=25, OPEN_BUS=8'hFF.
- One natural sub-module, cart_fetch_buf: single-entry tag/data/valid register with hit compare, fill, and flush.

Test Plan:
- Reset, then read with mem_unmaped=1, mem_addr=0x01234 -> dout=0xFF one cycle later, cpu_wait never high, ram_req never high.
- base_addr=0x100000, mem_addr=0x02005, ram_ack 5 cycles later with ram_din=0xA5 -> ram_addr=0x102005, cpu_wait high for the access cycle plus 5 cycles, dout=0xA5.
- Repeat the same read after acc drops -> hit: no ram_req, dout=0xA5 next cycle, cpu_wait stays 0. Pulse inval, read again -> miss, ram_req asserted.
- TIMEOUT=8, no ram_ack -> ram_req drops after 8 cycles, dout=0xFF, timeout_err=1, next read of the same address misses.
- Fetch in progress with inval pulsed and acc dropped mid-REQ, ram_ack with 0x3C -> FSM reaches IDLE, buffer valid=0, no new request.
- base_addr=0x7FFFFFF, mem_addr=0x00002 -> ram_addr=0x0000001 (wrap). Assert reset mid-REQ -> all outputs return to reset values immediately, without waiting for a clock.
